// File: rtl/bpm_uart_reporter.sv
// Converts a 34-bit BPM value to decimal ASCII and streams it, optionally
// followed by CR LF, to a UART transmitter over a valid/ready byte handshake.
module bpm_uart_reporter #(
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [33:0] i_bpm_counter,
    input  logic        i_bpm_changed,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy
);

    localparam int unsigned VAL_W     = 34;
    localparam int unsigned DIGITS    = 11;
    localparam int unsigned BCD_W     = DIGITS * 4;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned IDX_W     = 4;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(VAL_W - 1);
    localparam logic [IDX_W-1:0] TOP_DIGIT = IDX_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SKIP,
        SEND_DIGIT,
        SEND_CR,
        SEND_LF
    } state_t;

    state_t             state;
    logic [VAL_W-1:0]   value;
    logic [VAL_W-1:0]   pending_value;
    logic               pending;
    logic [BCD_W-1:0]   bcd;
    logic [CNT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   idx;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next bit.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic bit_in);
        logic [BCD_W-1:0] a;
        a = b;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return {a[BCD_W-2:0], bit_in};
    endfunction

    function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b, input logic [IDX_W-1:0] i);
        return b[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] ascii(input logic [3:0] d);
        return 8'h30 + {4'b0000, d};
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            o_tx_valid    <= 1'b0;
            o_tx_data     <= 8'h00;
            o_busy        <= 1'b0;
            pending       <= 1'b0;
            pending_value <= '0;
            value         <= '0;
            bcd           <= '0;
            bit_cnt       <= '0;
            idx           <= '0;
        end else begin
            // Updates arriving mid-message are parked; the latest one wins.
            if (i_bpm_changed && state != IDLE) begin
                pending       <= 1'b1;
                pending_value <= i_bpm_counter;
            end

            case (state)
                IDLE: begin
                    if (i_bpm_changed || pending) begin
                        value   <= i_bpm_changed ? i_bpm_counter : pending_value;
                        pending <= 1'b0;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        o_busy  <= 1'b1;
                        state   <= CONVERT;
                    end
                end

                CONVERT: begin
                    bcd     <= dd_step(bcd, value[VAL_W-1]);
                    value   <= {value[VAL_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        idx   <= TOP_DIGIT;
                        state <= SKIP;
                    end
                end

                // Strip leading zeros, but always keep the units digit.
                SKIP: begin
                    if (idx != '0 && digit_at(bcd, idx) == 4'd0) begin
                        idx <= idx - IDX_W'(1);
                    end else begin
                        o_tx_data  <= ascii(digit_at(bcd, idx));
                        o_tx_valid <= 1'b1;
                        state      <= SEND_DIGIT;
                    end
                end

                SEND_DIGIT: begin
                    if (i_tx_ready) begin
                        if (idx != '0) begin
                            idx       <= idx - IDX_W'(1);
                            o_tx_data <= ascii(digit_at(bcd, idx - IDX_W'(1)));
                        end else if (SEND_CRLF) begin
                            o_tx_data <= 8'h0D;
                            state     <= SEND_CR;
                        end else begin
                            o_tx_valid <= 1'b0;
                            o_busy     <= pending || i_bpm_changed;
                            state      <= IDLE;
                        end
                    end
                end

                SEND_CR: begin
                    if (i_tx_ready) begin
                        o_tx_data <= 8'h0A;
                        state     <= SEND_LF;
                    end
                end

                SEND_LF: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        o_busy     <= pending || i_bpm_changed;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bpm_uart_reporter.sv
// Scoreboard bench: expected bytes are queued at stimulus time and popped by
// per-DUT monitors on each handshake; covers CRLF and digits-only builds.
module tb_bpm_uart_reporter;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] a_cnt, b_cnt;
    logic        a_chg, b_chg, a_rdy, b_rdy;
    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, a_busy, b_busy;

    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    bpm_uart_reporter #(.SEND_CRLF(1'b1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_bpm_counter(a_cnt), .i_bpm_changed(a_chg),
        .o_tx_data(a_data), .o_tx_valid(a_valid), .i_tx_ready(a_rdy), .o_busy(a_busy)
    );

    bpm_uart_reporter #(.SEND_CRLF(1'b0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_bpm_counter(b_cnt), .i_bpm_changed(b_chg),
        .o_tx_data(b_data), .o_tx_valid(b_valid), .i_tx_ready(b_rdy), .o_busy(b_busy)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push(input int which, input string s, input bit crlf);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (which == 0) q_a.push_back(c); else q_b.push_back(c);
        end
        if (crlf) begin
            if (which == 0) begin q_a.push_back(8'h0D); q_a.push_back(8'h0A); end
            else begin q_b.push_back(8'h0D); q_b.push_back(8'h0A); end
        end
    endfunction

    // Monitors: compare each transferred byte and enforce hold-until-transfer.
    logic       a_hold = 1'b0, b_hold = 1'b0;
    logic [7:0] a_hold_data, b_hold_data;

    always @(negedge clk) begin
        if (a_hold) begin
            check("a_hold_valid", 64'(a_valid), 64'd1);
            check("a_hold_data", 64'(a_data), 64'(a_hold_data));
        end
        a_hold      = a_valid && !a_rdy && !rst;
        a_hold_data = a_data;
        if (a_valid && a_rdy && !rst) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_byte: got 0x%0h expected none", a_data);
            end else check("a_byte", 64'(a_data), 64'(q_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (b_hold) begin
            check("b_hold_valid", 64'(b_valid), 64'd1);
            check("b_hold_data", 64'(b_data), 64'(b_hold_data));
        end
        b_hold      = b_valid && !b_rdy && !rst;
        b_hold_data = b_data;
        if (b_valid && b_rdy && !rst) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_byte: got 0x%0h expected none", b_data);
            end else check("b_byte", 64'(b_data), 64'(q_b.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [33:0] v);
        a_cnt = v; a_chg = 1'b1;
        tick();
        a_chg = 1'b0;
    endtask

    task automatic pulse_b(input logic [33:0] v);
        b_cnt = v; b_chg = 1'b1;
        tick();
        b_chg = 1'b0;
    endtask

    task automatic wait_a_valid(output int n);
        n = 0;
        while (!a_valid && n < 100) begin tick(); n++; end
    endtask

    task automatic wait_a_done(input string name);
        int n = 0;
        while ((a_busy || q_a.size() != 0) && n < 2000) begin tick(); n++; end
        check(name, 64'(a_busy || q_a.size() != 0), 64'd0);
        check({name, "_valid"}, 64'(a_valid), 64'd0);
    endtask

    task automatic wait_b_done(input string name);
        int n = 0;
        while ((b_busy || q_b.size() != 0) && n < 2000) begin tick(); n++; end
        check(name, 64'(b_busy || q_b.size() != 0), 64'd0);
        check({name, "_valid"}, 64'(b_valid), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; a_cnt = '0; b_cnt = '0; a_chg = 1'b0; b_chg = 1'b0;
        a_rdy = 1'b1; b_rdy = 1'b1;
        repeat (3) tick();
        check("rst_a_valid", 64'(a_valid), 64'd0);
        check("rst_a_data", 64'(a_data), 64'h00);
        check("rst_a_busy", 64'(a_busy), 64'd0);
        check("rst_b_valid", 64'(b_valid), 64'd0);
        check("rst_b_busy", 64'(b_busy), 64'd0);
        rst = 1'b0;
        tick();

        push(0, "120", 1'b1);
        pulse_a(34'd120);
        check("busy_after_pulse", 64'(a_busy), 64'd1);
        wait_a_done("done_120");

        // Zero has the most leading zeros to skip, so it bounds the latency.
        push(0, "0", 1'b1);
        pulse_a(34'd0);
        wait_a_valid(n);
        check("latency_le_46", 64'(n <= 46), 64'd1);
        wait_a_done("done_0");

        push(0, "17179869183", 1'b1);
        pulse_a(34'h3_FFFF_FFFF);
        wait_a_done("done_max");

        a_rdy = 1'b0;
        push(0, "5", 1'b1);
        pulse_a(34'd5);
        wait_a_valid(n);
        check("stall_valid_seen", 64'(n < 100), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 64'(a_valid), 64'd1);
            check("stall_data", 64'(a_data), 64'h35);
            tick();
        end
        a_rdy = 1'b1;
        wait_a_done("done_stall");

        push(0, "60", 1'b1);
        push(0, "62", 1'b1);
        pulse_a(34'd60);
        repeat (5) tick();
        pulse_a(34'd61);
        repeat (5) tick();
        pulse_a(34'd62);
        wait_a_done("done_pending");

        push(0, "9", 1'b0);
        pulse_a(34'd987);
        wait_a_valid(n);
        check("rst_msg_valid_seen", 64'(n < 100), 64'd1);
        tick();
        rst = 1'b1; a_rdy = 1'b0;
        tick();
        check("midrst_valid", 64'(a_valid), 64'd0);
        check("midrst_busy", 64'(a_busy), 64'd0);
        rst = 1'b0; a_rdy = 1'b1;
        repeat (60) tick();
        check("midrst_no_bytes", 64'(a_valid), 64'd0);
        check("midrst_queue", 64'(q_a.size()), 64'd0);
        push(0, "7", 1'b1);
        pulse_a(34'd7);
        wait_a_done("done_after_rst");

        push(1, "42", 1'b0);
        push(1, "43", 1'b0);
        pulse_b(34'd42);
        n = 0;
        while (!(b_valid && b_data == 8'h32) && n < 100) begin tick(); n++; end
        check("b_last_digit_seen", 64'(n < 100), 64'd1);
        b_cnt = 34'd43; b_chg = 1'b1;
        tick();
        b_chg = 1'b0;
        wait_b_done("done_nocrlf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bpm_uart_reporter.md
BPM_UART_REPORTER -- requirements
Module: bpm_uart_reporter

Interface
REQ-001 SHALL have parameter SEND_CRLF, default 1, meaning append 0x0D 0x0A after the digits (0 = digits only).
REQ-002 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_bpm_counter  input  34  current BPM value, unsigned binary.
REQ-005 SHALL have port i_bpm_changed  input  1  single-cycle pulse; i_bpm_counter is valid in the same cycle.
REQ-006 SHALL have port o_tx_data  output  8  ASCII byte offered to the UART transmitter.
REQ-007 SHALL have port o_tx_valid  output  1  o_tx_data is valid.
REQ-008 SHALL have port i_tx_ready  input  1  transmitter accepts a byte.
REQ-009 SHALL have port o_busy  output  1  a message is being converted or sent.

Function
REQ-010 SHALL, on an edge with i_bpm_changed=1 in IDLE, latch i_bpm_counter, set o_busy=1 and enter CONVERT on that edge.
REQ-011 SHALL convert in CONVERT by iterative shift-add-3 (double dabble): exactly 34 cycles, one bit per cycle, into an 11-digit (44-bit) BCD register.
REQ-012 SHALL enter SKIP after CONVERT: drop leading zero digits from the most significant end, one digit per cycle, always keeping the least significant digit (value 0 sends "0").
REQ-013 SHALL send in SEND_DIGIT the remaining digits most-significant first, each as 0x30+digit.
REQ-014 SHALL, with SEND_CRLF=1, follow the last digit with 0x0D (SEND_CR) then 0x0A (SEND_LF), and return to IDLE after the last byte transfers.
REQ-015 SHALL, with SEND_CRLF=0, return to IDLE after the last digit transfers.
REQ-016 SHALL transfer a byte on a rising edge where o_tx_valid=1 and i_tx_ready=1.
REQ-017 SHALL hold o_tx_data stable and o_tx_valid high until transfer; o_tx_valid SHALL never drop without a transfer, except on reset.
REQ-018 SHALL present the next byte in the cycle after a transfer, so that back-to-back bytes are sent at one per cycle when i_tx_ready stays 1.
REQ-019 SHALL keep o_tx_valid=0 in IDLE, CONVERT and SKIP.
REQ-020 SHALL assert the first o_tx_valid no later than 46 cycles after the edge that sampled i_bpm_changed.
REQ-021 SHALL, on i_bpm_changed while o_busy=1, set a pending flag and overwrite the pending value register with i_bpm_counter (latest value wins).
REQ-022 SHALL not alter the message in progress when a pending update arrives.
REQ-023 SHALL, on return to IDLE with pending set, start a new message from the pending value on the next edge and clear pending.
REQ-024 SHALL, when i_bpm_changed coincides with the final transfer edge, capture that value as pending; it SHALL not be lost.
REQ-025 SHALL deassert o_busy only in IDLE with pending clear.
REQ-026 SHALL ignore i_tx_ready when o_tx_valid=0.

Reset
REQ-027 SHALL, on an edge with i_reset=1, force IDLE, o_tx_valid=0, o_tx_data=0x00, o_busy=0, pending=0, and clear the BCD and value registers.
REQ-028 SHALL, on reset mid-message, abandon the message; o_tx_valid SHALL be 0 after that edge and no remaining byte SHALL be sent.
REQ-029 SHALL give i_reset priority over i_bpm_changed on the same edge; the update SHALL be discarded.

Verification
REQ-030 SHALL verify: value 120 pulsed, i_tx_ready=1 -> bytes 0x31 0x32 0x30 0x0D 0x0A, then o_busy=0.
REQ-031 SHALL verify: value 0 -> 0x30 0x0D 0x0A; value 17179869183 (2^34-1) -> 11 digits "17179869183" then CR LF.
REQ-032 SHALL verify: value 5, i_tx_ready held 0 for 10 cycles after o_tx_valid rises -> o_tx_valid=1 and o_tx_data=0x35 stable all 10 cycles; exactly one transfer after ready rises.
REQ-033 SHALL verify: value 60, then 61 and 62 pulsed during message -> "60\r\n" then "62\r\n" only; 61 never sent.
REQ-034 SHALL verify: reset asserted after the first digit of "987" transfers -> o_tx_valid=0 next cycle; no further bytes; a new pulse of 7 afterwards -> "7\r\n".
REQ-035 SHALL verify: SEND_CRLF=0 with value 42 -> 0x34 0x32 only; pulse on final transfer edge with 43 -> "43" follows.
